// File: rtl/serial_receiver.sv
// serial_receiver: deserialiser for an MSB-first serial line (idle 0, one
// start bit of 1, DATA_WIDTH data bits, one bit per clk). The recovered word
// is held in an output register with a valid/ready handshake. A frame that
// completes while the output register is still full and not being accepted
// is dropped and reported with a one-cycle overrun pulse.
//
// Optional feature macro: SERIAL_RECEIVER_SYNC_EN
//   defined   - sin passes through a two-flop synchroniser (adds 2 clocks)
//   undefined - sin is sampled directly (same-clock negedge-launched source)
module serial_receiver #(
    parameter int DATA_WIDTH = 40,
    parameter int CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sin,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_data_valid,
    input  logic                  out_data_ready,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    state_t                state;
    state_t                state_nxt;
    // Only the first DATA_WIDTH-1 bits need storing: the final bit is taken
    // straight from the line on the completion edge.
    logic [DATA_WIDTH-2:0] shift;
    logic [DATA_WIDTH-2:0] shift_nxt;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  valid_q;
    logic                  valid_nxt;
    logic                  busy_q;
    logic                  busy_nxt;
    logic                  ovr_q;
    logic                  ovr_nxt;

    logic                  s;
    logic [DATA_WIDTH-1:0] word;
    logic                  frame_done;

`ifdef SERIAL_RECEIVER_SYNC_EN
    logic sync1;
    logic sync2;

    // Two-flop synchroniser for a line launched from an unrelated clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sin;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = sin;
`endif

    // Word completed on this edge if it is the final data bit.
    assign word = {shift, s};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift   <= '0;
            count   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            count   <= count_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            busy_q  <= busy_nxt;
            ovr_q   <= ovr_nxt;
        end
    end

    // Next-state, framing, delivery and handshake logic.
    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift;
        count_nxt  = count;
        data_nxt   = data_q;
        valid_nxt  = valid_q;
        busy_nxt   = busy_q;
        ovr_nxt    = 1'b0;
        frame_done = 1'b0;

        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = RECV;
                    count_nxt = '0;
                    busy_nxt  = 1'b1;
                end
            end
            RECV: begin
                shift_nxt = {shift[DATA_WIDTH-3:0], s};
                if (count == LAST_CNT) begin
                    state_nxt  = IDLE;
                    count_nxt  = '0;
                    busy_nxt   = 1'b0;
                    frame_done = 1'b1;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Acceptance clears valid unless a new word is loaded on the same edge.
        if (valid_q && out_data_ready) begin
            valid_nxt = 1'b0;
        end

        if (frame_done) begin
            if (!valid_q || out_data_ready) begin
                data_nxt  = word;
                valid_nxt = 1'b1;
            end else begin
                ovr_nxt = 1'b1;
            end
        end
    end

    assign out_data       = data_q;
    assign out_data_valid = valid_q;
    assign busy           = busy_q;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: self-checking bench for serial_receiver. A behavioural
// model collects framed bits into a queue and is compared with the DUT every
// cycle; table-driven frames check latency/data, and hand-written sequences
// cover hold, overrun, same-edge accept/load and reset mid-frame.
module tb_serial_receiver;

    localparam int DW  = 40;
    localparam int CW  = 6;
    localparam int CLK = 10;
`ifdef SERIAL_RECEIVER_SYNC_EN
    localparam int XL  = 2;
`else
    localparam int XL  = 0;
`endif
    localparam int LAT = DW + XL;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          sin   = 1'b0;
    logic          ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_data_valid;
    logic          busy;
    logic          overrun;

    serial_receiver #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sin            (sin),
        .out_data       (out_data),
        .out_data_valid (out_data_valid),
        .out_data_ready (ready),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #(CLK/2) clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    bit            m_valid   = 1'b0;
    bit            m_busy    = 1'b0;
    bit            m_ovr     = 1'b0;
    bit            m_collect = 1'b0;
    logic [DW-1:0] m_data    = '0;
    bit            m_bits[$];
    bit            p1 = 1'b0;
    bit            p2 = 1'b0;

    // Observations gathered by the monitor.
    time           t_edge;
    time           t_start;
    time           t_rise;
    logic [DW-1:0] rise_data;
    bit            valid_prev;
    int            busy_cycles;
    int            ovr_pulses;
    int            valid_low_cycles;

    typedef struct {
        logic [DW-1:0] payload;
        logic [DW-1:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame semantics: after a 1 in idle, the next DW line samples form the
    // word (first sample = MSB); delivery follows the output-register rules.
    task automatic model_step(input bit s_in, input bit rdy, input bit rn);
        bit            s;
        bit            done;
        logic [DW-1:0] w;
        if (!rn) begin
            m_valid = 0; m_busy = 0; m_ovr = 0; m_collect = 0; m_data = '0;
            p1 = 0; p2 = 0;
            m_bits.delete();
            return;
        end
`ifdef SERIAL_RECEIVER_SYNC_EN
        s  = p2;
        p2 = p1;
        p1 = s_in;
`else
        s = s_in;
`endif
        m_ovr = 0;
        done  = 0;
        if (m_collect) begin
            m_bits.push_back(s);
            if (m_bits.size() == DW) begin
                done      = 1;
                m_collect = 0;
            end
        end else if (s) begin
            m_collect = 1;
            m_bits.delete();
        end
        m_busy = m_collect;
        if (done) begin
            w = '0;
            for (int i = 0; i < DW; i++) w[DW-1-i] = m_bits[i];
            if (!m_valid || rdy) begin
                m_data  = w;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    // Per-cycle monitor: step the model on each edge, compare just after.
    initial begin : monitor
        forever begin
            @(posedge clk);
            t_edge = $time;
            model_step(sin, ready, rst_n);
            #1;
            check("valid",   out_data_valid, m_valid);
            check("data",    out_data,       m_data);
            check("busy",    busy,           m_busy);
            check("overrun", overrun,        m_ovr);
            if (out_data_valid && !valid_prev) begin
                t_rise    = t_edge;
                rise_data = out_data;
            end
            valid_prev = out_data_valid;
            if (busy) busy_cycles++;
            if (overrun) ovr_pulses++;
            if (!out_data_valid) valid_low_cycles++;
        end
    end

    // Drives start bit then payload MSB-first on negedges; optionally raises
    // ready so that it is high exactly on the frame's completion edge.
    task automatic send_frame(input logic [DW-1:0] w, input bit accept_at_end);
        @(negedge clk);
        sin = 1'b1;
        @(posedge clk);
        t_start = $time;
        for (int i = DW - 1; i >= 0; i--) begin
            @(negedge clk);
            sin = w[i];
        end
        if (accept_at_end) begin
            for (int k = 0; k < XL; k++) begin
                @(negedge clk);
                sin = 1'b0;
            end
            ready = 1'b1;
        end
        @(negedge clk);
        sin = 1'b0;
        if (accept_at_end) ready = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t          vecs[6];
        logic [63:0]   r;
        logic [DW-1:0] partial;
        bit            rand_run;

        vecs[0] = '{40'hD999999991, 40'hD999999991};
        vecs[1] = '{40'h0000000000, 40'h0000000000};
        vecs[2] = '{40'hFFFFFFFFFF, 40'hFFFFFFFFFF};
        vecs[3] = '{40'h123456789A, 40'h123456789A};
        vecs[4] = '{40'h8000000001, 40'h8000000001};
        vecs[5] = '{40'h00000000FF, 40'h00000000FF};

        rst_n = 1'b0; sin = 1'b0; ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", out_data_valid, 1'b0);
        check("reset_data",  out_data,       '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single frames with ready held high.
        ready = 1'b1;
        foreach (vecs[i]) begin
            t_rise      = 0;
            busy_cycles = 0;
            send_frame(vecs[i].payload, 1'b0);
            repeat (XL + 3) @(negedge clk);
            check("tbl_latency", int'((t_rise - t_start) / CLK), LAT);
            check("tbl_data",    rise_data,      vecs[i].exp_data);
            check("tbl_busy",    busy_cycles,    DW);
            check("tbl_valid_fell", out_data_valid, 1'b0);
        end

        // Hold: word stays stable until accepted.
        ready = 1'b0;
        send_frame(40'hD999999991, 1'b0);
        repeat (XL) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", out_data_valid, 1'b1);
            check("hold_data",  out_data,       40'hD999999991);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("hold_release", out_data_valid, 1'b0);

        // Overrun: second back-to-back frame dropped while register is full.
        ovr_pulses = 0;
        send_frame(40'h00000000FF, 1'b0);
        send_frame(40'h8000000001, 1'b0);
        repeat (XL + 3) @(negedge clk);
        check("ovr_data",   out_data,       40'h00000000FF);
        check("ovr_valid",  out_data_valid, 1'b1);
        check("ovr_pulses", ovr_pulses,     1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;

        // Accept and load on the same edge: no overrun, valid never drops.
        ovr_pulses = 0;
        send_frame(40'h00000000FF, 1'b0);
        repeat (XL) @(negedge clk);
        valid_low_cycles = 0;
        send_frame(40'h8000000001, 1'b1);
        repeat (XL + 2) @(negedge clk);
        check("sim_data",      out_data,         40'h8000000001);
        check("sim_valid",     out_data_valid,   1'b1);
        check("sim_ovr",       ovr_pulses,       0);
        check("sim_valid_gap", valid_low_cycles, 0);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;

        // Reset mid-frame with a word held: everything discarded.
        send_frame(40'hD999999991, 1'b0);
        repeat (XL + 1) @(negedge clk);
        partial = 40'hA5A5A5A5A5;
        @(negedge clk);
        sin = 1'b1;
        for (int i = DW - 1; i >= DW - 20; i--) begin
            @(negedge clk);
            sin = partial[i];
        end
        @(negedge clk);
        rst_n = 1'b0;
        sin   = 1'b0;
        #1;
        check("rst_valid", out_data_valid, 1'b0);
        check("rst_data",  out_data,       '0);
        check("rst_busy",  busy,           1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        t_rise = 0;
        send_frame(40'h123456789A, 1'b0);
        repeat (XL + 3) @(negedge clk);
        check("post_rst_latency", int'((t_rise - t_start) / CLK), LAT);
        check("post_rst_data",    rise_data, 40'h123456789A);

        // Randomised frames, gaps and ready, checked by the per-cycle model.
        rand_run = 1'b1;
        fork
            begin
                while (rand_run) begin
                    @(negedge clk);
                    ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int n = 0; n < 30; n++) begin
                    r = {$urandom(), $urandom()};
                    send_frame(r[DW-1:0], 1'b0);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                rand_run = 1'b0;
            end
        join

        ready = 1'b1;
        repeat (XL + 4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Deserialiser that sits directly downstream of the serial transmitter and consumes its serial line.
- Line format, fixed:
  - Idle level 0.
  - One start bit of 1.
  - DATA_WIDTH data bits, MSB first, one bit per clk.
  - Transmitter changes the line on negedge clk; this block samples on posedge clk.
- Recovered word is held in an output register with a valid/ready handshake; overruns are flagged.

Parameters:
- DATA_WIDTH, 40: payload bits per frame.
- CNT_W, 6: bit-counter width; must hold DATA_WIDTH.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial line in; idle 0.
- out_data  output  DATA_WIDTH  recovered word, MSB = first data bit received.
- out_data_valid  output  1  word available; held until accepted.
- out_data_ready  input  1  consumer accepts the word when high together with valid.
- busy  output  1  frame reception in progress.
- overrun  output  1  one-cycle pulse: completed frame dropped because the output register was still full.

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, shift register=0, count=0, out_data=0, out_data_valid=0, busy=0, overrun=0.
- Sampled line s = sin, or the synchronised sin when the optional feature is enabled.
- States:
  - IDLE: if s==1 at a posedge, that edge is the start-bit sample; go to RECV, count<=0, busy<=1.
  - RECV: each posedge, shift <= {shift[DATA_WIDTH-2:0], s}, count<=count+1.
    - On the edge where count==DATA_WIDTH-1 (the 40th data bit), go to IDLE and busy<=0.
    - On that edge, deliver the word: the assembled word including that final bit is the word completed.
  - No stop-bit check. The line must return to 0 before the next start bit; the transmitter guarantees at least one 0 cycle.
  - A 1 seen in IDLE on the cycle immediately after a frame ends is treated as a new start bit.
- Delivery:
  - If out_data_valid==0, or (out_data_valid && out_data_ready) on the same edge: out_data <= completed word, out_data_valid<=1.
  - Otherwise: word dropped, out_data unchanged, overrun<=1 for exactly one cycle.
- Handshake:
  - out_data_valid falls on the posedge after valid && ready, unless a new word is loaded on that same edge; in that case valid stays 1 with the new data.
  - out_data stays stable while valid=1 and not accepted.
- Latency: the start bit is sampled at edge P0; out_data_valid is high after edge P40 (40 clocks later, DATA_WIDTH in general).
  - Back-to-back frames: the next start bit can be sampled at P41 at the earliest.
- Counter: count never exceeds DATA_WIDTH-1; it resets to 0 on entry to RECV.
- Reset mid-frame:
  - Partial word discarded, state IDLE, outputs as in the reset list above.
  - Any held word is lost; out_data_valid=0.
- out_data_ready while out_data_valid==0: ignored.

Optional Feature:
- Macro: SERIAL_RECEIVER_SYNC_EN.
- Defined: sin passes through a two-flop synchroniser (both flops reset to 0) before use. All latencies grow by 2 clocks (valid after P0+42 relative to sin's start edge); this permits sin from an unrelated clock domain.
- Undefined: sin is used directly, for the same-clock negedge-launched source only.

Test Plan:
- Single frame: reset, then drive 1 followed by 40'hD999999991 MSB-first on negedges, with ready=1. out_data_valid goes high 40 clocks after the start sample with out_data=40'hD999999991, then falls the next cycle; busy is high for exactly 40 cycles.
- Hold: same frame with ready=0. valid stays 1 and out_data stays stable for 10 cycles; raising ready for 1 cycle drops valid on the next edge.
- Overrun: frames 40'h00000000FF then 40'h8000000001 back-to-back, ready held 0. out_data=40'h00000000FF, one-cycle overrun pulse at the second frame's completion, valid stays 1.
- Simultaneous accept/load: ready asserted exactly on the completion edge of the second frame. No overrun; out_data=40'h8000000001, valid continuously 1.
- Reset mid-frame: assert rst_n=0 after 20 data bits, release, then send 40'h123456789A. Outputs are 0 during reset, no spurious valid, and the following frame is received correctly.
- All-zero payload (start bit then forty 0s): valid with out_data=0. With SERIAL_RECEIVER_SYNC_EN defined, rerun the single-frame test: valid arrives 2 clocks later with identical data.
